// File: rtl/mem_port_arbiter_if.sv
// Handshake and memory bus bundle for mem_port_arbiter.
// The master modport is the arbiter's view; slave is the pipeline/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 9
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [31:0]       if_inst;
  logic              d_req;
  logic              d_we;
  logic [2:0]        d_f3;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_valid;
  logic [31:0]       d_rdata;
  logic              d_err;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_f3, d_addr, d_wdata, mem_rdata,
    output if_valid, if_inst, d_valid, d_rdata, d_err, stall,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_f3, d_addr, d_wdata, mem_rdata,
    input  if_valid, if_inst, d_valid, d_rdata, d_err, stall,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port unified memory arbiter between instruction fetch and load/store.
// Optional MEM_ARB_RR_EN selects round-robin arbitration instead of data-over-fetch priority.
module mem_port_arbiter #(
  parameter int ADDR_W    = 9,
  parameter int DATA_BASE = 200,
  parameter int MEM_TOP   = 511
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  localparam int BW = ADDR_W + 1;
  localparam int EW = ADDR_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE_IF = 3'd1,
    ST_ISSUE_D  = 3'd2,
    ST_RESP_IF  = 3'd3,
    ST_RESP_D   = 3'd4,
    ST_ERR_D    = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_s;

  logic [2:0]        d_size_s;
  logic [BW-1:0]     d_base_s;
  logic [EW-1:0]     d_end_s;
  logic              mis_s;
  logic              range_s;
  logic              acc_err_s;

  logic              req_if_s;
  logic              req_d_s;
  logic              pick_d_s;
  logic              grant_if_s;
  logic              grant_d_s;

  logic              mem_req_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [3:0]        mem_be_r;
  logic [31:0]       mem_wdata_r;
  logic              rsp_we_r;
  logic [2:0]        rsp_f3_r;

  logic              if_valid_s;
  logic [31:0]       if_inst_s;
  logic              d_valid_s;
  logic [31:0]       d_rdata_s;
  logic              flag_err_s;
  logic              stall_s;

  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    case (f3)
      3'b001, 3'b101: f3_size = 3'd2;
      3'b010:         f3_size = 3'd4;
      default:        f3_size = 3'd1;
    endcase
  endfunction

  function automatic logic [3:0] f3_be(input logic [2:0] f3);
    case (f3)
      3'b001, 3'b101: f3_be = 4'b0011;
      3'b010:         f3_be = 4'b1111;
      default:        f3_be = 4'b0001;
    endcase
  endfunction

  // Unlisted funct3 codes fall back to a signed byte load.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] raw);
    case (f3)
      3'b001:  load_extend = {{16{raw[15]}}, raw[15:0]};
      3'b010:  load_extend = raw;
      3'b100:  load_extend = {24'd0, raw[7:0]};
      3'b101:  load_extend = {16'd0, raw[15:0]};
      default: load_extend = {{24{raw[7]}}, raw[7:0]};
    endcase
  endfunction

  assign d_size_s  = f3_size(bus.d_f3);
  assign d_base_s  = BW'(DATA_BASE) + BW'(bus.d_addr);
  assign d_end_s   = EW'(d_base_s) + EW'(d_size_s) - EW'(1'b1);
  assign range_s   = (d_end_s > EW'(MEM_TOP));
  assign acc_err_s = mis_s | range_s;

  // Natural-alignment check on the window offset.
  always_comb begin
    mis_s = 1'b0;
    case (d_size_s)
      3'd2:    mis_s = bus.d_addr[0];
      3'd4:    mis_s = (bus.d_addr[1:0] != 2'b00);
      default: mis_s = 1'b0;
    endcase
  end

  // The requester being completed this cycle is excluded from re-arbitration.
  assign req_if_s = bus.if_req & (state_r != ST_RESP_IF);
  assign req_d_s  = bus.d_req & (state_r != ST_RESP_D);

`ifdef MEM_ARB_RR_EN
  logic last_d_r;

  assign pick_d_s = req_d_s & (~req_if_s | ~last_d_r);

  // Round-robin pointer: remembers which requester was granted last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_r <= 1'b0;
    end else if (grant_d_s) begin
      last_d_r <= 1'b1;
    end else if (grant_if_s) begin
      last_d_r <= 1'b0;
    end else begin
      last_d_r <= last_d_r;
    end
  end
`else
  assign pick_d_s = req_d_s;
`endif

  // Next-state and grant decode.
  always_comb begin
    state_s    = state_r;
    grant_if_s = 1'b0;
    grant_d_s  = 1'b0;
    case (state_r)
      ST_ISSUE_IF: state_s = ST_RESP_IF;
      ST_ISSUE_D:  state_s = ST_RESP_D;
      ST_ERR_D:    state_s = ST_IDLE;
      ST_IDLE, ST_RESP_IF, ST_RESP_D: begin
        if (pick_d_s) begin
          grant_d_s = 1'b1;
          state_s   = acc_err_s ? ST_ERR_D : ST_ISSUE_D;
        end else if (req_if_s) begin
          grant_if_s = 1'b1;
          state_s    = ST_ISSUE_IF;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Memory strobe and fields are loaded at grant, so they are only live during ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_be_r    <= 4'b0000;
      mem_wdata_r <= 32'd0;
      rsp_we_r    <= 1'b0;
      rsp_f3_r    <= 3'b000;
    end else if (grant_d_s && !acc_err_s) begin
      mem_req_r   <= 1'b1;
      mem_we_r    <= bus.d_we;
      mem_addr_r  <= d_base_s[ADDR_W-1:0];
      mem_be_r    <= f3_be(bus.d_f3);
      mem_wdata_r <= bus.d_wdata;
      rsp_we_r    <= bus.d_we;
      rsp_f3_r    <= bus.d_f3;
    end else if (grant_if_s) begin
      mem_req_r   <= 1'b1;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= bus.if_addr;
      mem_be_r    <= 4'b1111;
      mem_wdata_r <= 32'd0;
      rsp_we_r    <= rsp_we_r;
      rsp_f3_r    <= rsp_f3_r;
    end else begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_be_r    <= 4'b0000;
      mem_wdata_r <= 32'd0;
      rsp_we_r    <= rsp_we_r;
      rsp_f3_r    <= rsp_f3_r;
    end
  end

  // Response decode: valid pulses come straight off mem_rdata in the RESP cycle.
  always_comb begin
    if_valid_s = 1'b0;
    if_inst_s  = 32'd0;
    d_valid_s  = 1'b0;
    d_rdata_s  = 32'd0;
    flag_err_s = 1'b0;
    case (state_r)
      ST_RESP_IF: begin
        if_valid_s = 1'b1;
        if_inst_s  = bus.mem_rdata;
      end
      ST_RESP_D: begin
        d_valid_s = 1'b1;
        if (!rsp_we_r) begin
          d_rdata_s = load_extend(rsp_f3_r, bus.mem_rdata);
        end else begin
          d_rdata_s = 32'd0;
        end
      end
      ST_ERR_D: begin
        d_valid_s  = 1'b1;
        flag_err_s = 1'b1;
      end
      default: begin
        if_valid_s = 1'b0;
      end
    endcase
  end

  // Reset forces stall low even while requesters keep their request asserted.
  assign stall_s = ~rst & ((bus.if_req & ~if_valid_s) | (bus.d_req & ~d_valid_s));

  assign bus.if_valid  = if_valid_s;
  assign bus.if_inst   = if_inst_s;
  assign bus.d_valid   = d_valid_s;
  assign bus.d_rdata   = d_rdata_s;
  assign bus.d_err     = flag_err_s;
  assign bus.stall     = stall_s;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_be    = mem_be_r;
  assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (default fixed-priority build) with a response scoreboard.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(9)) bus ();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        is_d;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_chk;
  int   n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic is_d, input logic [31:0] data, input logic err);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    e.err  = err;
    sb.push_back(e);
  endtask

  // Called when a valid pulse is observed: compare against the oldest expectation.
  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.is_d) begin
        chk({tag, "_d_valid"}, 32'(bus.d_valid), 32'd1);
        chk({tag, "_d_rdata"}, bus.d_rdata, e.data);
        chk({tag, "_d_err"}, 32'(bus.d_err), 32'(e.err));
      end else begin
        chk({tag, "_if_valid"}, 32'(bus.if_valid), 32'd1);
        chk({tag, "_if_inst"}, bus.if_inst, e.data);
      end
    end
  endtask

  // Starts just after a posedge with the DUT idle; ends the same way.
  task automatic data_access(input string tag, input logic we, input logic [2:0] f3,
                             input logic [8:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input logic [8:0] exp_maddr,
                             input logic [3:0] exp_be, input logic exp_err,
                             input logic [31:0] exp_rdata);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_f3    = f3;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    push_exp(1'b1, exp_rdata, exp_err);
    @(negedge clk);
    chk({tag, "_stall_n"}, 32'(bus.stall), 32'd1);
    chk({tag, "_mem_req_n"}, 32'(bus.mem_req), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    if (exp_err) begin
      chk({tag, "_err_no_mem_req"}, 32'(bus.mem_req), 32'd0);
      pop_check(tag);
    end else begin
      chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd1);
      chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'(we));
      chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(exp_maddr));
      chk({tag, "_mem_be"}, 32'(bus.mem_be), 32'(exp_be));
      chk({tag, "_early_valid"}, 32'(bus.d_valid), 32'd0);
      if (we) chk({tag, "_mem_wdata"}, bus.mem_wdata, wdata);
      @(posedge clk); #1;
      bus.mem_rdata = rdata;
      @(negedge clk);
      chk({tag, "_stall_done"}, 32'(bus.stall), 32'd0);
      pop_check(tag);
    end
    @(posedge clk); #1;
    bus.d_req     = 1'b0;
    bus.mem_rdata = 32'hDEADBEEF;
  endtask

  task automatic fetch_access(input string tag, input logic [8:0] addr, input logic [31:0] rdata);
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    push_exp(1'b0, rdata, 1'b0);
    @(negedge clk);
    chk({tag, "_stall_n"}, 32'(bus.stall), 32'd1);
    chk({tag, "_mem_req_n"}, 32'(bus.mem_req), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd1);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(addr));
    chk({tag, "_mem_be"}, 32'(bus.mem_be), 32'hF);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_stall_n1"}, 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    bus.mem_rdata = rdata;
    @(negedge clk);
    chk({tag, "_stall_n2"}, 32'(bus.stall), 32'd0);
    pop_check(tag);
    @(posedge clk); #1;
    bus.if_req    = 1'b0;
    bus.mem_rdata = 32'hDEADBEEF;
  endtask

  initial begin
    int  cycles;
    logic found;
    n_chk  = 0;
    n_pass = 0;
    rst            = 1'b1;
    bus.if_req     = 1'b0;
    bus.if_addr    = 9'd0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_f3       = 3'b000;
    bus.d_addr     = 9'd0;
    bus.d_wdata    = 32'd0;
    bus.mem_rdata  = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_d_valid", 32'(bus.d_valid), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;

    // Fetch only
    fetch_access("fetch0", 9'd0, 32'h00002083);

    // Simultaneous requests: data first, fetch follows without an idle cycle
    bus.if_req  = 1'b1;
    bus.if_addr = 9'd8;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_f3    = 3'b010;
    bus.d_addr  = 9'd4;
    push_exp(1'b1, 32'h11223344, 1'b0);
    push_exp(1'b0, 32'h55667788, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sim_d_first_req", 32'(bus.mem_req), 32'd1);
    chk("sim_d_first_addr", 32'(bus.mem_addr), 32'd204);
    @(posedge clk); #1;
    bus.mem_rdata = 32'h11223344;
    @(negedge clk);
    chk("sim_if_not_yet", 32'(bus.if_valid), 32'd0);
    chk("sim_stall_if_pending", 32'(bus.stall), 32'd1);
    pop_check("sim_d");
    @(posedge clk); #1;
    bus.d_req     = 1'b0;
    bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("sim_if_req", 32'(bus.mem_req), 32'd1);
    chk("sim_if_addr", 32'(bus.mem_addr), 32'd8);
    @(posedge clk); #1;
    bus.mem_rdata = 32'h55667788;
    @(negedge clk);
    pop_check("sim_if");
    @(posedge clk); #1;
    bus.if_req    = 1'b0;
    bus.mem_rdata = 32'hDEADBEEF;

    // Load extensions
    data_access("lb",  1'b0, 3'b000, 9'd0, 32'd0, 32'h000080F1, 9'd200, 4'b0001, 1'b0, 32'hFFFFFFF1);
    data_access("lbu", 1'b0, 3'b100, 9'd0, 32'd0, 32'h000080F1, 9'd200, 4'b0001, 1'b0, 32'h000000F1);
    data_access("lh",  1'b0, 3'b001, 9'd0, 32'd0, 32'h000080F1, 9'd200, 4'b0011, 1'b0, 32'hFFFF80F1);
    data_access("lhu", 1'b0, 3'b101, 9'd0, 32'd0, 32'h000080F1, 9'd200, 4'b0011, 1'b0, 32'h000080F1);
    data_access("f3_other", 1'b0, 3'b011, 9'd0, 32'd0, 32'h000080F1, 9'd200, 4'b0001, 1'b0, 32'hFFFFFFF1);

    // Stores and misalignment
    data_access("sh", 1'b1, 3'b001, 9'd12, 32'h12345678, 32'hDEADBEEF, 9'd212, 4'b0011, 1'b0, 32'd0);
    data_access("sw_mis", 1'b1, 3'b010, 9'd2, 32'hA5A5A5A5, 32'hDEADBEEF, 9'd0, 4'b0000, 1'b1, 32'd0);
    data_access("lh_mis", 1'b0, 3'b001, 9'd1, 32'd0, 32'hDEADBEEF, 9'd0, 4'b0000, 1'b1, 32'd0);

    // Range boundaries
    data_access("lw_range", 1'b0, 3'b010, 9'd310, 32'd0, 32'hDEADBEEF, 9'd0, 4'b0000, 1'b1, 32'd0);
    data_access("lb_top", 1'b0, 3'b000, 9'd311, 32'd0, 32'h00000080, 9'd511, 4'b0001, 1'b0, 32'hFFFFFF80);
    data_access("lw_top", 1'b0, 3'b010, 9'd308, 32'd0, 32'h89ABCDEF, 9'd508, 4'b1111, 1'b0, 32'h89ABCDEF);

    // Fetch near the top wraps in memory, never errors
    fetch_access("fetch_wrap", 9'd510, 32'h0badf00d);

    // Reset in the middle of a data access
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_f3   = 3'b010;
    bus.d_addr = 9'd0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_issue", 32'(bus.mem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("mid_rst_d_valid", 32'(bus.d_valid), 32'd0);
    chk("mid_rst_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    chk("mid_rst_no_pulse", 32'(bus.d_valid), 32'd0);
    chk("mid_rst_held_req", 32'(bus.mem_req), 32'd0);
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.mem_rdata = 32'h00000042;
    push_exp(1'b1, 32'h00000042, 1'b0);
    cycles = 0;
    found  = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk);
      if (bus.d_valid) begin
        found = 1'b1;
      end else begin
        @(posedge clk); #1;
        cycles++;
      end
    end
    chk("restart_found", 32'(found), 32'd1);
    chk("restart_latency", 32'(cycles), 32'd2);
    if (found) pop_check("restart");
    @(posedge clk); #1;
    bus.d_req     = 1'b0;
    bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("final_idle_stall", 32'(bus.stall), 32'd0);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and arbitrates the single-ported unified byte memory (instructions plus data window) between the instruction-fetch requester and the load/store requester.
- Handles the following:
  - request/valid handshakes;
  - data-window address offset;
  - byte enables and lane placement for stores;
  - sign/zero extension of loads;
  - alignment and range errors;
  - pipeline stall generation.
- Sits between the pipeline's IF/MEM stages and the memory array.

Parameters:
- ADDR_W, 9, byte-address width of the memory (512 bytes).
- DATA_BASE, 200, byte offset of the data window; data address = DATA_BASE + d_addr.
- MEM_TOP, 511, highest legal byte address.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held high until if_valid.
- if_addr  in  ADDR_W  fetch byte address; 2-byte aligned.
- if_valid  out  1  one-cycle pulse: if_inst valid.
- if_inst  out  32  fetched bytes {m[a+3],m[a+2],m[a+1],m[a]}.
- d_req  in  1  data request; held high until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_f3  in  3  RISC-V funct3 size/sign code.
- d_addr  in  ADDR_W  data offset into the data window.
- d_wdata  in  32  store data.
- d_valid  out  1  one-cycle pulse: data access complete.
- d_rdata  out  32  extended load data; 0 for stores and errors.
- d_err  out  1  qualifies d_valid: misaligned or out-of-range access.
- stall  out  1  high while any request is pending and not yet completing.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory byte address.
- mem_be  out  4  byte enables, lane 0 = mem_addr.
- mem_wdata  out  32  write data, lane-aligned to mem_addr.
- mem_rdata  in  32  {m[a+3..a]}, valid the cycle after mem_req.

Behaviour:
- Reset values: state IDLE, all outputs 0, grant pointer = fetch. Reset mid-access aborts the access immediately; mem_req drops asynchronously and no valid pulse is issued.

States:
- IDLE: evaluate requests. Grant goes to ISSUE_IF or ISSUE_D; an erroring data access goes to ERR_D. No request stays in IDLE.
- ISSUE_IF / ISSUE_D: mem_req=1 for exactly one cycle, with address, enables and data driven from registered request fields latched at grant. Always proceeds to RESP_IF / RESP_D.
- RESP_IF / RESP_D: mem_rdata sampled; the requester's valid pulses this cycle (combinational from mem_rdata). Arbitration re-evaluates here, excluding the requester being completed, so back-to-back access to the other requester has no idle cycle.
- ERR_D: d_valid=1, d_err=1, d_rdata=0, no memory access. Returns to IDLE.

Latency and throughput:
- Request first seen in IDLE at cycle N: ISSUE at N+1, valid at N+2.
- Peak throughput is one access per 2 cycles.

Priority:
- Fixed priority: data beats fetch when both requesters are high.

Data access:
- mem_addr = DATA_BASE + d_addr, computed ADDR_W+1 wide.
- mem_be / width by funct3 (funct3 0–2 for stores):

| funct3 | access | mem_be | load extension |
|---|---|---|---|
| 000 | byte | 0001 | sign-extend from bit 7 |
| 001 | half | 0011 | sign-extend from bit 15 |
| 010 | word | 1111 | none |
| 100 | byte | 0001 | zero-extend |
| 101 | half | 0011 | zero-extend |
| other | byte | 0001 | treated as 000 |

- mem_wdata = d_wdata unshifted.
- Error conditions, either of which routes the access to ERR_D:
  - Misalignment: half with d_addr[0]=1, or word with d_addr[1:0]≠0.
  - Range: DATA_BASE+d_addr+size−1 > MEM_TOP.

Fetch access:
- mem_addr = if_addr, mem_be=1111, mem_we=0.
- if_inst = mem_rdata unmodified.
- if_addr+3 > MEM_TOP: the memory wraps modulo 512; no error is flagged.

stall:
- stall = (if_req & ~if_valid) | (d_req & ~d_valid).
- Dropping a request before its valid is illegal; the request stays latched internally and completes anyway.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration. When both requesters are high, the grant goes to the one not served last, and the pointer updates on each grant. This guarantees no fetch starvation under back-to-back loads.
- MEM_ARB_RR_EN undefined: fixed data-over-fetch priority and no pointer register.

Test Plan:
1. Reset, fetch only: if_req=1, if_addr=0 with mem_rdata=32'h00002083 at N+2 → mem_req at N+1 with mem_addr=0, be=1111; if_valid pulse at N+2 with if_inst=32'h00002083; stall=1 at N and N+1, 0 at N+2.
2. Simultaneous request: if_req and d_req (lw, d_addr=4) in the same cycle, fixed priority:
   - ISSUE_D first with mem_addr=204, d_valid at N+2.
   - ISSUE_IF at N+3, if_valid at N+4.
   - With MEM_ARB_RR_EN and pointer=data, the order is reversed.
3. Loads at d_addr=0 with mem_rdata=32'h000080F1:
   - lb → d_rdata=32'hFFFFFFF1.
   - lbu → 32'h000000F1.
   - lh → 32'hFFFF80F1.
   - lhu → 32'h000080F1.
4. Stores:
   - sh x, d_addr=12, d_wdata=32'h12345678 → mem_we=1, mem_addr=212, mem_be=0011, mem_wdata=32'h12345678; d_valid with d_rdata=0.
   - sw, d_addr=2 → ERR_D: d_err=1 at N+1, mem_req never asserted.
5. Range: lw with d_addr=310 (200+310+3 > 511) → d_valid & d_err at N+1, no mem_req. lb with d_addr=311 → legal, mem_addr=511.
6. Reset mid-access: assert rst during ISSUE_D → mem_req, d_valid and stall drop immediately, no pulse afterwards. After release with d_req still high, the access restarts from IDLE and completes 2 cycles later.
